// File: rtl/axi_lite_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite register slave.
package axi_lite_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 4;
  localparam int NUM_REGS   = 4;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = ADDR_WIDTH - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ACCEPT = 2'd1,
    W_RESP   = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_ACCEPT = 2'd1,
    R_DATA   = 2'd2
  } rd_state_e;

endpackage

// File: rtl/axi_lite_slave_if.sv
// AXI4-Lite bus bundle (no clock/reset; those stay plain ports).
interface axi_lite_slave_if;
  import axi_lite_pkg::*;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_regfile.sv
// 4x32 register storage: byte-enabled synchronous write, combinational read.
module axi_lite_regfile
  import axi_lite_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [IDX_WIDTH-1:0]  i_widx,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [STRB_WIDTH-1:0] i_wstrb,
  input  logic [IDX_WIDTH-1:0]  i_ridx,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;

  // Clear on reset; otherwise update only the enabled byte lanes of one register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_regs <= '0;
    end else if (i_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (i_wstrb[b]) r_regs[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Read sees the pre-write contents on the edge a write lands.
  assign o_rdata = r_regs[i_ridx];

endmodule

// File: rtl/axi_lite_slave.sv
// AXI4-Lite slave with four 32-bit registers; independent write/read FSMs.
// Optional feature macro: AXI_LITE_SLAVE_WSTRB_EN (honour wstrb byte enables;
// without it every accepted write stores the full word).
// Reset aresetn is synchronous and active-HIGH despite its name.
module axi_lite_slave
  import axi_lite_pkg::*;
(
  input  logic             aclk,
  input  logic             aresetn,
  axi_lite_slave_if.slave  s_axi
);

  wr_state_e r_wstate, w_wnext;
  rd_state_e r_rstate, w_rnext;

  logic                  r_awready;
  logic                  r_bvalid;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_we;
  logic [STRB_WIDTH-1:0] w_strb;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_unused_bits;

`ifdef AXI_LITE_SLAVE_WSTRB_EN
  assign w_strb        = s_axi.wstrb;
  assign w_unused_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};
`else
  assign w_strb        = {STRB_WIDTH{1'b1}};
  assign w_unused_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0], s_axi.wstrb};
`endif

  // Commit happens on the edge that closes the one-cycle ACCEPT window.
  assign w_we = (r_wstate == W_ACCEPT) && !aresetn;

  axi_lite_regfile u_regfile (
    .i_clk   (aclk),
    .i_rst   (aresetn),
    .i_we    (w_we),
    .i_widx  (s_axi.awaddr[ADDR_WIDTH-1:2]),
    .i_wdata (s_axi.wdata),
    .i_wstrb (w_strb),
    .i_ridx  (s_axi.araddr[ADDR_WIDTH-1:2]),
    .o_rdata (w_rd_word)
  );

  // Write next-state: both address and data must be present before accepting.
  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE:   if (s_axi.awvalid && s_axi.wvalid && !r_bvalid) w_wnext = W_ACCEPT;
      W_ACCEPT: w_wnext = W_RESP;
      W_RESP:   if (s_axi.bready) w_wnext = W_IDLE;
      default:  w_wnext = W_IDLE;
    endcase
  end

  // Write state and registered handshake outputs, decoded from next state.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_wstate  <= w_wnext;
      r_awready <= (w_wnext == W_ACCEPT);
      r_bvalid  <= (w_wnext == W_RESP);
    end
  end

  // Read next-state: one outstanding read, wait for rready in DATA.
  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:   if (s_axi.arvalid && !r_rvalid) w_rnext = R_ACCEPT;
      R_ACCEPT: w_rnext = R_DATA;
      R_DATA:   if (s_axi.rready) w_rnext = R_IDLE;
      default:  w_rnext = R_IDLE;
    endcase
  end

  // Read state, registered handshake outputs; rdata holds until the next accept.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rstate  <= w_rnext;
      r_arready <= (w_rnext == R_ACCEPT);
      r_rvalid  <= (w_rnext == R_DATA);
      if (r_rstate == R_ACCEPT) r_rdata <= w_rd_word;
    end
  end

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_awready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = RESP_OKAY;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = RESP_OKAY;

endmodule

// File: tb/tb_axi_lite_slave.sv
// Randomized self-checking bench for axi_lite_slave against an array model.
module tb_axi_lite_slave;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  axi_lite_slave_if bus();

  axi_lite_slave dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axi   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] model [4];

  // Expected register contents after a write, from the byte-enable rule.
  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = old_v;
`ifdef AXI_LITE_SLAVE_WSTRB_EN
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
`else
    res = new_v;
    if (strb == 4'h0) res = new_v;
`endif
    return res;
  endfunction

  task automatic wait_awready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(posedge aclk); #1;
      if (bus.awready === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_arready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(posedge aclk); #1;
      if (bus.arready === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    wait_awready(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL wr_accept addr=%h: awready never rose", a);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      return;
    end
    checks++;
    if (bus.wready !== 1'b1) begin
      failures++; $display("FAIL wr_wready got=%b exp=1", bus.wready);
    end
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    model[a[3:2]] = merge(model[a[3:2]], d, s);
    checks++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || bus.awready !== 1'b0) begin
      failures++;
      $display("FAIL wr_resp bvalid=%b bresp=%b awready=%b exp 1/00/0", bus.bvalid, bus.bresp, bus.awready);
    end
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    checks++;
    if (bus.bvalid !== 1'b0) begin
      failures++; $display("FAIL wr_bdone bvalid=%b exp=0", bus.bvalid);
    end
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] data);
    bit ok;
    data = 'x;
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b0;
    wait_arready(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL rd_accept addr=%h: arready never rose", a);
      bus.arvalid = 1'b0;
      return;
    end
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    data = bus.rdata;
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rresp !== 2'b00 || bus.arready !== 1'b0) begin
      failures++;
      $display("FAIL rd_data rvalid=%b rresp=%b arready=%b exp 1/00/0", bus.rvalid, bus.rresp, bus.arready);
    end
    bus.rready = 1'b1;
    @(posedge aclk); #1;
    bus.rready = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b0 || bus.rdata !== data) begin
      failures++;
      $display("FAIL rd_done rvalid=%b rdata=%h exp 0/%h", bus.rvalid, bus.rdata, data);
    end
  endtask

  task automatic check_reg(input string name, input logic [3:0] a);
    logic [31:0] got;
    do_read(a, got);
    checks++;
    if (got !== model[a[3:2]]) begin
      failures++; $display("FAIL %s addr=%h got=%h exp=%h", name, a, got, model[a[3:2]]);
    end
  endtask

  task automatic test_reset;
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} !== 5'b0 ||
        bus.rdata !== 32'h0 || bus.bresp !== 2'b00 || bus.rresp !== 2'b00) begin
      failures++;
      $display("FAIL reset_outputs aw/w/b/ar/r=%b%b%b%b%b rdata=%h exp all 0",
               bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rdata);
    end
    aresetn = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    for (int i = 0; i < 4; i++) check_reg("reset_reg", 4'(i*4));
  endtask

  task automatic test_basic;
    do_write(4'h0, 32'hCAFEBABE, 4'hF);
    check_reg("basic_rd", 4'h0);
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if (bus.rdata !== 32'hCAFEBABE) begin
      failures++; $display("FAIL basic_hold rdata=%h exp=cafebabe", bus.rdata);
    end
  endtask

  task automatic test_strobe;
    logic [31:0] got, exp;
`ifdef AXI_LITE_SLAVE_WSTRB_EN
    exp = 32'h11BB33DD;
`else
    exp = 32'hAABBCCDD;
`endif
    do_write(4'h4, 32'h11223344, 4'hF);
    do_write(4'h4, 32'hAABBCCDD, 4'b0101);
    do_read(4'h4, got);
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL strobe got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_all_regs;
    for (int i = 0; i < 4; i++) do_write(4'(i*4), $urandom ^ (32'h1 << i), 4'hF);
    for (int i = 3; i >= 0; i--) check_reg("all_regs", 4'(i*4));
    do_write(4'h5, $urandom, 4'hF);
    check_reg("alias", 4'h4);
    check_reg("alias_other", 4'h0);
  endtask

  task automatic test_backpressure;
    bit ok;
    logic [31:0] d1, d2;
    d1 = $urandom; d2 = $urandom;
    bus.awaddr = 4'h8; bus.wdata = d1; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b0; bus.bready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(posedge aclk); #1;
      checks++;
      if (bus.awready !== 1'b0 || bus.wready !== 1'b0) begin
        failures++; $display("FAIL aw_only cyc=%0d awready=%b wready=%b exp 0/0", n, bus.awready, bus.wready);
      end
    end
    bus.wvalid = 1'b1;
    wait_awready(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL bp_accept awready never rose");
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      return;
    end
    @(posedge aclk); #1;
    model[2] = merge(model[2], d1, 4'hF);
    // Second write presented immediately while the first response is stalled.
    bus.awaddr = 4'hC; bus.wdata = d2;
    for (int n = 0; n < 4; n++) begin
      @(posedge aclk); #1;
      checks++;
      if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0) begin
        failures++; $display("FAIL bp_hold cyc=%0d bvalid=%b awready=%b exp 1/0", n, bus.bvalid, bus.awready);
      end
    end
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    checks++;
    if (bus.bvalid !== 1'b0) begin
      failures++; $display("FAIL bp_release bvalid=%b exp=0", bus.bvalid);
    end
    wait_awready(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL bp_second awready never rose");
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      return;
    end
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    model[3] = merge(model[3], d2, 4'hF);
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    check_reg("bp_rd1", 4'h8);
    check_reg("bp_rd2", 4'hC);
  endtask

  task automatic test_simultaneous;
    bit ok;
    logic [31:0] d, old_v;
    d = $urandom; old_v = model[2];
    bus.araddr = 4'h8; bus.arvalid = 1'b1;
    bus.awaddr = 4'h8; bus.wdata = d; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    wait_arready(ok);
    checks++;
    if (!ok || bus.awready !== 1'b1) begin
      failures++; $display("FAIL sim_accept arready_ok=%b awready=%b exp 1/1", ok, bus.awready);
    end
    @(posedge aclk); #1;
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== old_v) begin
      failures++; $display("FAIL sim_rd_old rvalid=%b rdata=%h exp 1/%h", bus.rvalid, bus.rdata, old_v);
    end
    model[2] = merge(model[2], d, 4'hF);
    bus.rready = 1'b1; bus.bready = 1'b1;
    @(posedge aclk); #1;
    bus.rready = 1'b0; bus.bready = 1'b0;
    check_reg("sim_rd_new", 4'h8);
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      else
        check_reg("random_rd", 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bus.awaddr = 4'h4; bus.wdata = 32'h5A5A5A5A; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    wait_awready(ok);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    checks++;
    if (!ok || bus.bvalid !== 1'b1) begin
      failures++; $display("FAIL rst_pending accepted=%b bvalid=%b exp 1/1", ok, bus.bvalid);
    end
    aresetn = 1'b1;
    @(posedge aclk); #1;
    checks++;
    if (bus.bvalid !== 1'b0 || bus.awready !== 1'b0 || bus.rdata !== 32'h0) begin
      failures++; $display("FAIL rst_mid bvalid=%b awready=%b rdata=%h exp 0/0/0", bus.bvalid, bus.awready, bus.rdata);
    end
    aresetn = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    for (int i = 0; i < 4; i++) check_reg("rst_mid_reg", 4'(i*4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b1;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    test_reset;
    test_basic;
    test_strobe;
    test_all_regs;
    test_backpressure;
    test_simultaneous;
    test_random;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
